// File: rtl/mul_4b_triarch_pkg.sv
// Shared widths, types and the carry-lookahead helper for the 4x4 multiplier
// comparison block.
package mul4_pkg;

   localparam int OP_W   = 4;
   localparam int PROD_W = 8;

   typedef logic [OP_W-1:0]   op_t;
   typedef logic [PROD_W-1:0] prod_t;

   // Carry into bit k of a 4b adder with cin=0, expanded so each carry is a
   // flat function of generate/propagate only (no ripple between sum bits).
   function automatic logic cla_carry(input op_t g, input op_t p, input int k);
      logic c;
      c = 1'b0;
      for (int m = 0; m < OP_W; m++) begin
         if (m < k) c = g[m] | (p[m] & c);
      end
      return c;
   endfunction

endpackage

// File: rtl/mul_4b_triarch_if.sv
// Operand/result bundle of the triple-architecture multiplier; the master
// drives operands, the slave (the multiplier) returns products and checks.
interface mul_4b_triarch_if;
   import mul4_pkg::*;

   logic  in_valid;
   op_t   in_a;
   op_t   in_b;
   logic  out_valid;
   prod_t out;
   prod_t out_rca;
   prod_t out_csa;
   prod_t out_cla;
   logic  rca_err;
   logic  csa_err;
   logic  cla_err;
   logic  err_sticky;

   modport master (
      output in_valid, in_a, in_b,
      input  out_valid, out, out_rca, out_csa, out_cla,
      input  rca_err, csa_err, cla_err, err_sticky
   );

   modport slave (
      input  in_valid, in_a, in_b,
      output out_valid, out, out_rca, out_csa, out_cla,
      output rca_err, csa_err, cla_err, err_sticky
   );

endinterface

// File: rtl/mul_4b_triarch_fa_1b.sv
// One-bit full adder; used as a half adder by tying cin low.
module fa_1b (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/mul_4b_triarch.sv
// Registered 4x4 unsigned multiplier built three ways (ripple array, carry-save
// array, carry-save + CLA merge), each cross-checked against a*b on capture.
module mul_4b_triarch
   import mul4_pkg::*;
(
   input  logic           clk,
   input  logic           rst_n,
   mul_4b_triarch_if.slave bus
);

   // in_valid qualifies in_a/in_b at a rising edge; out_valid is in_valid one
   // cycle later. There is no ready: every valid operand pair is accepted.

   op_t a, b;
   op_t pp0, pp1, pp2, pp3;

   assign a   = bus.in_a;
   assign b   = bus.in_b;
   assign pp0 = a & {OP_W{b[0]}};
   assign pp1 = a & {OP_W{b[1]}};
   assign pp2 = a & {OP_W{b[2]}};
   assign pp3 = a & {OP_W{b[3]}};

   // Ripple-carry array: each row adds the next partial product to the
   // previous row's shifted sum, carries rippling along the row.
   op_t   rca_s1, rca_s2, rca_s3;
   op_t   rca_in1, rca_in2, rca_in3;
   logic  rca_c1, rca_c2, rca_c3;
   prod_t rca_p;

   assign rca_in1 = {1'b0, pp0[3:1]};
   assign rca_in2 = {rca_c1, rca_s1[3:1]};
   assign rca_in3 = {rca_c2, rca_s2[3:1]};

   for (genvar j = 0; j < OP_W; j++) begin : g_rca
      logic ci1, ci2, ci3, co1, co2, co3;
      if (j == 0) begin : g_lsb
         assign ci1 = 1'b0;
         assign ci2 = 1'b0;
         assign ci3 = 1'b0;
      end else begin : g_mid
         assign ci1 = g_rca[j-1].co1;
         assign ci2 = g_rca[j-1].co2;
         assign ci3 = g_rca[j-1].co3;
      end
      fa_1b u_fa1 (.a(pp1[j]), .b(rca_in1[j]), .cin(ci1), .s(rca_s1[j]), .cout(co1));
      fa_1b u_fa2 (.a(pp2[j]), .b(rca_in2[j]), .cin(ci2), .s(rca_s2[j]), .cout(co2));
      fa_1b u_fa3 (.a(pp3[j]), .b(rca_in3[j]), .cin(ci3), .s(rca_s3[j]), .cout(co3));
   end

   assign rca_c1 = g_rca[3].co1;
   assign rca_c2 = g_rca[3].co2;
   assign rca_c3 = g_rca[3].co3;
   assign rca_p  = {rca_c3, rca_s3, rca_s2[0], rca_s1[0], pp0[0]};

   // Carry-save array: carries of row r feed row r+1 at the same weight
   // instead of rippling, leaving one sum/carry pair for the final merge.
   op_t csa_rs1, csa_rc1, csa_rs2, csa_rc2, csa_rs3, csa_rc3;

   for (genvar j = 0; j < OP_W; j++) begin : g_csa
      logic s0_in, s1_in, s2_in;
      assign s0_in = (j == 3) ? 1'b0 : pp0[(j+1)%OP_W];
      assign s1_in = (j == 3) ? 1'b0 : csa_rs1[(j+1)%OP_W];
      assign s2_in = (j == 3) ? 1'b0 : csa_rs2[(j+1)%OP_W];
      fa_1b u_cs1 (.a(pp1[j]), .b(s0_in), .cin(1'b0),       .s(csa_rs1[j]), .cout(csa_rc1[j]));
      fa_1b u_cs2 (.a(pp2[j]), .b(s1_in), .cin(csa_rc1[j]), .s(csa_rs2[j]), .cout(csa_rc2[j]));
      fa_1b u_cs3 (.a(pp3[j]), .b(s2_in), .cin(csa_rc2[j]), .s(csa_rs3[j]), .cout(csa_rc3[j]));
   end

   // Both final merges add product bits [7:4]; bits [3:0] are already final.
   op_t   mrg_a, mrg_b, mrg_s;
   prod_t csa_p;

   assign mrg_a = {1'b0, csa_rs3[3:1]};
   assign mrg_b = csa_rc3;

   for (genvar j = 0; j < OP_W; j++) begin : g_mrg
      logic ci, co;
      if (j == 0) begin : g_lsb
         assign ci = 1'b0;
      end else begin : g_mid
         assign ci = g_mrg[j-1].co;
      end
      fa_1b u_fa (.a(mrg_a[j]), .b(mrg_b[j]), .cin(ci), .s(mrg_s[j]), .cout(co));
   end

   assign csa_p = {mrg_s, csa_rs3[0], csa_rs2[0], csa_rs1[0], pp0[0]};

   // Carry-lookahead merge of the same carry-save pair.
   op_t   cla_g, cla_p, cla_c, cla_sum;
   prod_t cla_prod;

   assign cla_g = mrg_a & mrg_b;
   assign cla_p = mrg_a ^ mrg_b;

   for (genvar k = 0; k < OP_W; k++) begin : g_cla
      assign cla_c[k] = cla_carry(cla_g, cla_p, k);
   end

   assign cla_sum  = cla_p ^ cla_c;
   assign cla_prod = {cla_sum, csa_rs3[0], csa_rs2[0], csa_rs1[0], pp0[0]};

   prod_t golden;
   logic  rca_err_n, csa_err_n, cla_err_n;

   assign golden    = prod_t'(a) * prod_t'(b);
   assign rca_err_n = |(rca_p ^ golden);
   assign csa_err_n = |(csa_p ^ golden);
   assign cla_err_n = |(cla_prod ^ golden);

   logic  r_valid, r_rca_err, r_csa_err, r_cla_err, r_sticky;
   prod_t r_rca, r_csa, r_cla;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_rca     <= '0;
         r_csa     <= '0;
         r_cla     <= '0;
         r_rca_err <= 1'b0;
         r_csa_err <= 1'b0;
         r_cla_err <= 1'b0;
         r_sticky  <= 1'b0;
      end else if (bus.in_valid) begin
         r_valid   <= 1'b1;
         r_rca     <= rca_p;
         r_csa     <= csa_p;
         r_cla     <= cla_prod;
         r_rca_err <= rca_err_n;
         r_csa_err <= csa_err_n;
         r_cla_err <= cla_err_n;
         r_sticky  <= r_sticky | rca_err_n | csa_err_n | cla_err_n;
      end else begin
         r_valid   <= 1'b0;
      end
   end

   assign bus.out_valid  = r_valid;
   assign bus.out        = r_csa;
   assign bus.out_rca    = r_rca;
   assign bus.out_csa    = r_csa;
   assign bus.out_cla    = r_cla;
   assign bus.rca_err    = r_rca_err;
   assign bus.csa_err    = r_csa_err;
   assign bus.cla_err    = r_cla_err;
   assign bus.err_sticky = r_sticky;

endmodule

// File: tb/tb_mul_4b_triarch.sv
// Bench for mul_4b_triarch: scoreboard of expected products against a plain
// a*b model, plus directed reset, hold and fault-injection sequences.
module tb_mul_4b_triarch;
   import mul4_pkg::*;

   // clock / reset
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mul_4b_triarch_if bus ();
   mul_4b_triarch dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   logic [7:0] exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;
   logic mon_en   = 1'b0;

   function automatic logic [7:0] ref_mul(input int x, input int y);
      return 8'(x * y);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // driver tasks
   task automatic drive(input logic r, input logic v, input logic [3:0] x, input logic [3:0] y);
      @(negedge clk);
      rst_n        = r;
      bus.in_valid = v;
      bus.in_a     = x;
      bus.in_b     = y;
   endtask

   task automatic issue(input logic [3:0] x, input logic [3:0] y, input logic [7:0] e);
      drive(1'b1, 1'b1, x, y);
      exp_q.push_back(e);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_out_valid"},  bus.out_valid,  0);
      chk({tag, "_out"},        bus.out,        0);
      chk({tag, "_out_rca"},    bus.out_rca,    0);
      chk({tag, "_out_csa"},    bus.out_csa,    0);
      chk({tag, "_out_cla"},    bus.out_cla,    0);
      chk({tag, "_rca_err"},    bus.rca_err,    0);
      chk({tag, "_csa_err"},    bus.csa_err,    0);
      chk({tag, "_cla_err"},    bus.cla_err,    0);
      chk({tag, "_err_sticky"}, bus.err_sticky, 0);
   endtask

   // scoreboard monitor
   initial begin : monitor
      logic [7:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               chk("out",     bus.out,     e);
               chk("out_rca", bus.out_rca, e);
               chk("out_csa", bus.out_csa, e);
               chk("out_cla", bus.out_cla, e);
               chk("rca_err", bus.rca_err, 0);
               chk("csa_err", bus.csa_err, 0);
               chk("cla_err", bus.cla_err, 0);
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic [3:0] ra, rb;
      logic [7:0] e;

      // reset held with live operands
      rst_n        = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_a     = 4'd15;
      bus.in_b     = 4'd15;
      for (int i = 0; i < 2; i++) begin
         settle();
         chk_all_zero("reset");
      end

      drive(1'b1, 1'b0, 4'd0, 4'd0);
      mon_en = 1'b1;

      // exhaustive sweep of {b,a}
      for (int v = 0; v < 256; v++) begin
         issue(v[3:0], v[7:4], ref_mul(v % 16, v / 16));
      end
      drive(1'b1, 1'b0, 4'd0, 4'd0);
      drive(1'b1, 1'b0, 4'd0, 4'd0);
      settle();
      chk("sweep_rca_err",    bus.rca_err,    0);
      chk("sweep_csa_err",    bus.csa_err,    0);
      chk("sweep_cla_err",    bus.cla_err,    0);
      chk("sweep_err_sticky", bus.err_sticky, 0);

      // corners with spec-given constants
      issue(4'd15, 4'd15, 8'hE1);
      issue(4'd0,  4'd9,  8'h00);
      issue(4'd1,  4'd13, 8'h0D);
      issue(4'd8,  4'd8,  8'h40);

      // random stream with random gaps
      for (int i = 0; i < 60; i++) begin
         ra = 4'($urandom_range(0, 15));
         rb = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 1) == 1) issue(ra, rb, ref_mul(ra, rb));
         else drive(1'b1, 1'b0, ra, rb);
      end

      // hold after capture
      issue(4'd7, 4'd6, 8'h2A);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         settle();
         chk("hold_out_valid", bus.out_valid, 0);
         chk("hold_out",       bus.out,       8'h2A);
         chk("hold_out_rca",   bus.out_rca,   8'h2A);
         chk("hold_out_cla",   bus.out_cla,   8'h2A);
      end

      // reset in the middle of a stream
      for (int i = 0; i < 5; i++) begin
         ra = 4'($urandom_range(1, 15));
         rb = 4'($urandom_range(1, 15));
         issue(ra, rb, ref_mul(ra, rb));
      end
      drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      settle();
      chk("midrst_out",       bus.out,       0);
      chk("midrst_out_valid", bus.out_valid, 0);
      chk("midrst_out_rca",   bus.out_rca,   0);
      ra = 4'($urandom_range(1, 15));
      rb = 4'($urandom_range(1, 15));
      e  = ref_mul(ra, rb);
      issue(ra, rb, e);
      settle();
      chk("post_rst_out_valid", bus.out_valid, 1);
      chk("post_rst_out",       bus.out,       e);

      // fault injection in the ripple array
      drive(1'b1, 1'b0, 4'd0, 4'd0);
      drive(1'b1, 1'b0, 4'd0, 4'd0);
      mon_en = 1'b0;
      force dut.rca_s1 = 4'b0000;
      drive(1'b1, 1'b1, 4'd15, 4'd15);
      settle();
      chk("fault_rca_err",     bus.rca_err,    1);
      chk("fault_csa_err",     bus.csa_err,    0);
      chk("fault_cla_err",     bus.cla_err,    0);
      chk("fault_out",         bus.out,        8'hE1);
      chk("fault_rca_corrupt", 32'(bus.out_rca != 8'hE1), 1);
      chk("fault_err_sticky",  bus.err_sticky, 1);
      release dut.rca_s1;
      drive(1'b1, 1'b1, 4'd3, 4'd5);
      settle();
      chk("healed_rca_err",    bus.rca_err,    0);
      chk("healed_out_rca",    bus.out_rca,    8'h0F);
      chk("healed_err_sticky", bus.err_sticky, 1);
      for (int i = 0; i < 2; i++) begin
         drive(1'b1, 1'b0, 4'd0, 4'd0);
         settle();
         chk("idle_err_sticky", bus.err_sticky, 1);
      end
      drive(1'b0, 1'b0, 4'd0, 4'd0);
      settle();
      chk("cleared_err_sticky", bus.err_sticky, 0);
      chk("cleared_rca_err",    bus.rca_err,    0);

      drive(1'b1, 1'b0, 4'd0, 4'd0);
      mon_en = 1'b1;
      issue(4'd9, 4'd9, 8'h51);
      drive(1'b1, 1'b0, 4'd0, 4'd0);
      drive(1'b1, 1'b0, 4'd0, 4'd0);
      settle();
      chk("queue_drained", exp_q.size(), 0);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
